voice_allocator: RTL

Upstream control stage for the 8-voice `Synthesizer`. Accepts note-on/note-off events over a valid/ready handshake and assigns each note to a voice. Converts MIDI note numbers to Q.20 frequencies and runs a per-voice linear attack/release envelope. Drives the `frequencies[7:0]` and `voice_volumes[7:0]` arrays consumed by the synthesizer.

---
 rtl/voice_allocator.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/voice_allocator.sv
// voice_allocator: maps note events onto 8 synth voices and runs
// a linear attack/release envelope per voice.
// Ports: clk, reset (async, active high); event_valid/event_ready
// handshake with event_note_on, event_note, event_velocity;
// tick envelope strobe; frequencies and voice_volumes (Q.20).
module voice_allocator #(
  parameter logic [31:0] ATTACK_STEP  = 32'd1 << 14,
  parameter logic [31:0] RELEASE_STEP = 32'd1 << 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        event_valid,
  output logic        event_ready,
  input  logic        event_note_on,
  input  logic [6:0]  event_note,
  input  logic [6:0]  event_velocity,
  input  logic        tick,
  output logic [31:0] frequencies   [8],
  output logic [31:0] voice_volumes [8]
);

  typedef enum logic [1:0] {
    IDLE, DECODE, SEARCH, COMMIT
  } fsm_e;

  typedef enum logic [1:0] {
    V_FREE, V_ATTACK, V_RELEASE
  } vst_e;

  typedef enum logic [1:0] {
    P_RETRIG, P_FREE, P_REL, P_STEAL
  } pick_e;

  fsm_e        fsm_q;
  logic        ready_q;
  logic        on_q;
  logic [6:0]  note_q;
  logic [6:0]  vel_q;
  logic [6:0]  rem_q;
  logic [3:0]  oct_q;
  logic [2:0]  cnt_q;
  logic [2:0]  sel_q, sel_d;
  pick_e       pick_q, pick_d;
  logic [2:0]  steal_q;

  vst_e        vst_q   [8];
  logic [6:0]  vnote_q [8];
  logic [31:0] vtgt_q  [8];

  logic        commit, commit_on, commit_off;
  logic [31:0] freq_w, tgt_w;

  // Q.20 frequencies of notes 84..95 (top octave), rounded.
  function automatic logic [31:0] semi_freq(
    input logic [6:0] s
  );
    case (s)
      7'd0:    semi_freq = 32'd1097337155;
      7'd1:    semi_freq = 32'd1162588218;
      7'd2:    semi_freq = 32'd1231719311;
      7'd3:    semi_freq = 32'd1304961152;
      7'd4:    semi_freq = 32'd1382558180;
      7'd5:    semi_freq = 32'd1464769368;
      7'd6:    semi_freq = 32'd1551869087;
      7'd7:    semi_freq = 32'd1644148025;
      7'd8:    semi_freq = 32'd1741914154;
      7'd9:    semi_freq = 32'd1845493760;
      7'd10:   semi_freq = 32'd1955232530;
      7'd11:   semi_freq = 32'd2071496706;
      default: semi_freq = 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] step_att(
    input logic [31:0] vol,
    input logic [31:0] tgt
  );
    if (vol < tgt)
      step_att = (tgt - vol > ATTACK_STEP) ?
                 vol + ATTACK_STEP : tgt;
    else if (vol > tgt)
      step_att = (vol - tgt > ATTACK_STEP) ?
                 vol - ATTACK_STEP : tgt;
    else
      step_att = vol;
  endfunction

  assign event_ready = ready_q;

  // Notes above 95 travel the full pipeline but commit nothing.
  assign commit     = (fsm_q == COMMIT) && (note_q <= 7'd95);
  assign commit_on  = commit && on_q;
  assign commit_off = commit && !on_q;

  assign freq_w = semi_freq(rem_q) >> (4'd7 - oct_q);
  assign tgt_w  = {11'd0, {1'b0, vel_q} + 8'd1, 13'd0};

  // Priority search; scanning down leaves the lowest index.
  always_comb begin
    logic       h_same, h_free, h_rel;
    logic [2:0] i_same, i_free, i_rel;
    h_same = 1'b0;
    h_free = 1'b0;
    h_rel  = 1'b0;
    i_same = '0;
    i_free = '0;
    i_rel  = '0;
    for (int v = 7; v >= 0; v--) begin
      if (vst_q[v] != V_FREE && vnote_q[v] == note_q) begin
        h_same = 1'b1;
        i_same = 3'(v);
      end
      if (vst_q[v] == V_FREE) begin
        h_free = 1'b1;
        i_free = 3'(v);
      end
      if (vst_q[v] == V_RELEASE) begin
        h_rel = 1'b1;
        i_rel = 3'(v);
      end
    end
    sel_d  = steal_q;
    pick_d = P_STEAL;
    if (h_same) begin
      sel_d  = i_same;
      pick_d = P_RETRIG;
    end else if (h_free) begin
      sel_d  = i_free;
      pick_d = P_FREE;
    end else if (h_rel) begin
      sel_d  = i_rel;
      pick_d = P_REL;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q   <= IDLE;
      ready_q <= 1'b0;
      on_q    <= 1'b0;
      note_q  <= '0;
      vel_q   <= '0;
      rem_q   <= '0;
      oct_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      pick_q  <= P_STEAL;
      steal_q <= '0;
    end else begin
      unique case (fsm_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (event_valid && ready_q) begin
            ready_q <= 1'b0;
            on_q    <= event_note_on &&
                       (event_velocity != 7'd0);
            note_q  <= event_note;
            vel_q   <= event_velocity;
            rem_q   <= event_note;
            oct_q   <= '0;
            cnt_q   <= '0;
            fsm_q   <= DECODE;
          end
        end
        DECODE: begin
          // Fixed 8 steps: divide by 12 with constant latency.
          if (rem_q >= 7'd12) begin
            rem_q <= rem_q - 7'd12;
            oct_q <= oct_q + 4'd1;
          end
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7)
            fsm_q <= SEARCH;
        end
        SEARCH: begin
          sel_q  <= sel_d;
          pick_q <= pick_d;
          fsm_q  <= COMMIT;
        end
        COMMIT: begin
          if (commit_on && pick_q == P_STEAL)
            steal_q <= steal_q + 3'd1;
          ready_q <= 1'b1;
          fsm_q   <= IDLE;
        end
        default: fsm_q <= IDLE;
      endcase
    end
  end

  // Commit wins over a coincident tick on the committed voice.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int v = 0; v < 8; v++) begin
        vst_q[v]         <= V_FREE;
        vnote_q[v]       <= '0;
        vtgt_q[v]        <= '0;
        frequencies[v]   <= '0;
        voice_volumes[v] <= '0;
      end
    end else begin
      for (int v = 0; v < 8; v++) begin
        if (commit_on && sel_q == 3'(v)) begin
          vst_q[v]       <= V_ATTACK;
          vnote_q[v]     <= note_q;
          vtgt_q[v]      <= tgt_w;
          frequencies[v] <= freq_w;
          if (pick_q == P_REL || pick_q == P_STEAL)
            voice_volumes[v] <= '0;
        end else if (commit_off && vst_q[v] == V_ATTACK &&
                     vnote_q[v] == note_q) begin
          vst_q[v] <= V_RELEASE;
        end else if (tick) begin
          unique case (vst_q[v])
            V_ATTACK: voice_volumes[v] <=
              step_att(voice_volumes[v], vtgt_q[v]);
            V_RELEASE: begin
              if (voice_volumes[v] > RELEASE_STEP) begin
                voice_volumes[v] <=
                  voice_volumes[v] - RELEASE_STEP;
              end else begin
                voice_volumes[v] <= '0;
                vst_q[v]         <= V_FREE;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule
